out_capture_buffer: RTL

//  Synthesizable, parametrised successor to the CPU output dump. Captures (outFlag,out) samples from CHANNELS

---
 rtl/out_capture_buffer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/out_capture_buffer.sv
// out_capture_buffer
//   Captures (inFlag, inData) samples from CHANNELS producers into a DEPTH-entry show-ahead FIFO.
//   Each sample is tagged with its channel index, and the FIFO drains over a valid/ready port.
//   Once armed, it waits START_DELAY cycles and then raises startIO to enable the CPU I/O.
//   The run ends after `target` samples have been accepted and the FIFO has drained.
//
// Ports
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   arm         in   start a run (honoured in IDLE/DONE only), latches target
//   target      in   samples to accept per run
//   inFlag      in   per-channel sample valid
//   inData      in   channel c at [c*WIDTH +: WIDTH]
//   startIO     out  enable to CPU I/O, high while capturing
//   outValid    out  FIFO head valid
//   outReady    in   consumer accepts head
//   outData     out  FIFO head data (holds last value when outValid=0)
//   outChannel  out  FIFO head channel index (holds last value when outValid=0)
//   captured    out  samples accepted this run
//   dropped     out  samples lost to collision or full FIFO, saturating
//   overflow    out  sticky: any sample dropped this run
//   busy        out  run in progress (DELAY/CAPTURE/DRAIN)
//   done        out  run complete and FIFO drained
module out_capture_buffer #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned COUNTWIDTH  = 16,
    parameter int unsigned START_DELAY = 10,
    localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic [COUNTWIDTH-1:0]     target,
    input  logic [CHANNELS-1:0]       inFlag,
    input  logic [CHANNELS*WIDTH-1:0] inData,
    output logic                      startIO,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [WIDTH-1:0]          outData,
    output logic [CHW-1:0]            outChannel,
    output logic [COUNTWIDTH-1:0]     captured,
    output logic [COUNTWIDTH-1:0]     dropped,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DW-1:0] DelayLast = DW'(START_DELAY - 1);
    localparam logic [PW:0] CountFull = (PW + 1)'(DEPTH);
    localparam logic [COUNTWIDTH:0] DropOne = (COUNTWIDTH + 1)'(1);

    typedef enum logic [2:0] {StIdle, StDelay, StCapture, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DW-1:0]           delay_q, delay_d;
    logic [COUNTWIDTH-1:0]   target_q, target_d;
    logic [COUNTWIDTH-1:0]   captured_q, captured_d;
    logic [COUNTWIDTH-1:0]   dropped_q, dropped_d;
    logic                    overflow_q, overflow_d;

    logic [WIDTH-1:0]        mem_data [DEPTH];
    logic [CHW-1:0]          mem_chan [DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic [WIDTH-1:0]        head_data_q, head_data_d;
    logic [CHW-1:0]          head_chan_q, head_chan_d;

    logic                    any_flag;
    logic [CHW-1:0]          win_idx;
    logic [WIDTH-1:0]        win_data;
    logic [COUNTWIDTH:0]     loser_cnt;
    logic [COUNTWIDTH:0]     drop_inc;
    logic [COUNTWIDTH:0]     drop_sum;
    logic                    push, pop, full;

    // Lowest-index asserted channel wins. Scanning downwards, every flag found after
    // the first one means the previously found (higher) channel lost.
    always_comb begin
        any_flag  = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        loser_cnt = '0;
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (inFlag[c]) begin
                if (any_flag) begin
                    loser_cnt = loser_cnt + DropOne;
                end
                any_flag = 1'b1;
                win_idx  = CHW'(c);
                win_data = inData[c*WIDTH +: WIDTH];
            end
        end
    end

    assign full = (count_q == CountFull);
    assign pop  = (count_q != '0) && outReady && (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        target_d   = target_q;
        captured_d = captured_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        drop_inc   = '0;
        drop_sum   = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (arm) begin
                    state_d    = StDelay;
                    delay_d    = '0;
                    target_d   = target;
                    captured_d = '0;
                    dropped_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            StDelay: begin
                if (delay_q == DelayLast) begin
                    // A zero target skips capture entirely, so startIO never pulses.
                    state_d = (target_q == '0) ? StDrain : StCapture;
                end else begin
                    delay_d = delay_q + DW'(1);
                end
            end
            StCapture: begin
                if (captured_q == target_q) begin
                    state_d = StDrain;
                end else begin
                    drop_inc = loser_cnt;
                    if (any_flag) begin
                        // A full FIFO still takes the push if the head leaves this cycle.
                        if (!full || pop) begin
                            push       = 1'b1;
                            captured_d = captured_q + COUNTWIDTH'(1);
                            if (captured_d == target_q) begin
                                state_d = StDrain;
                            end
                        end else begin
                            drop_inc = drop_inc + DropOne;
                        end
                    end
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        if (drop_inc != '0) begin
            drop_sum   = {1'b0, dropped_q} + drop_inc;
            dropped_d  = drop_sum[COUNTWIDTH] ? '1 : drop_sum[COUNTWIDTH-1:0];
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers, occupancy and the registered head.
    always_comb begin
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_chan_d = head_chan_q;

        if (push && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW + 1)'(1);
        end

        // The new head may be the entry being written this cycle (push into empty,
        // or push+pop with a single entry), which is not yet in memory.
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d = win_data;
                head_chan_d = win_idx;
            end else begin
                head_data_d = mem_data[rd_ptr_d];
                head_chan_d = mem_chan[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr_q] <= win_data;
            mem_chan[wr_ptr_q] <= win_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            delay_q     <= '0;
            target_q    <= '0;
            captured_q  <= '0;
            dropped_q   <= '0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_chan_q <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            target_q    <= target_d;
            captured_q  <= captured_d;
            dropped_q   <= dropped_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_chan_q <= head_chan_d;
        end
    end

    assign startIO    = (state_q == StCapture);
    assign outValid   = (count_q != '0);
    assign outData    = head_data_q;
    assign outChannel = head_chan_q;
    assign captured   = captured_q;
    assign dropped    = dropped_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == StDelay) || (state_q == StCapture) || (state_q == StDrain);
    assign done       = (state_q == StDone);

endmodule
